// File: rtl/fetch_stage.sv
// fetch_stage: instruction-fetch stage. Owns the PC, the single-outstanding
// instruction-memory handshake, a one-entry hold buffer for responses that
// land while decode is stalled, and the IF/ID pipeline register.
//
// Ports:
//   clk_i, rst_i              clock, synchronous active-high reset
//   stall_i                   hazard hold, IF/ID must not advance
//   pc_src_optn_i             redirect the PC to target_addr_i
//   flush_req_i               kill the IF/ID contents
//   target_addr_i             redirect target (used unmodified)
//   imem_req_valid_o/ready_i  fetch request handshake
//   imem_addr_o               fetch address (= pc_q)
//   imem_rsp_valid_i/data_i   fetch response
//   if_id_*_o                 IF/ID register (valid, pc, pc+4, instr)
//
// Optional build macro FETCH_PERF_CNT_EN adds perf_fetch_cnt_o (IF/ID loads)
// and perf_kill_cnt_o (discarded responses / hold buffers).
module fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        stall_i,
  input  logic        pc_src_optn_i,
  input  logic        flush_req_i,
  input  logic [31:0] target_addr_i,
  output logic        imem_req_valid_o,
  input  logic        imem_req_ready_i,
  output logic [31:0] imem_addr_o,
  input  logic        imem_rsp_valid_i,
  input  logic [31:0] imem_rsp_data_i,
  output logic        if_id_valid_o,
  output logic [31:0] if_id_pc_o,
  output logic [31:0] if_id_pc_plus4_o,
  output logic [31:0] if_id_instr_o
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0] perf_fetch_cnt_o,
  output logic [31:0] perf_kill_cnt_o
`endif
);

  typedef enum logic [1:0] {S_REQ, S_WAIT, S_HOLD, S_DROP} state_t;

  state_t      state, state_nxt;
  logic [31:0] pc_q, pc_nxt, pc_plus4;
  logic [31:0] hold_q;
  logic        load, capture;
  logic [31:0] load_instr;

  assign pc_plus4 = pc_q + 32'd4;  // modulo 2^32 wrap is intended

  // state register
  always_ff @(posedge clk_i) begin
    if (rst_i) state <= S_REQ;
    else       state <= state_nxt;
  end

  // next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      S_REQ:  if (imem_req_ready_i) state_nxt = pc_src_optn_i ? S_DROP : S_WAIT;
      S_WAIT: begin
        if (imem_rsp_valid_i) begin
          if (pc_src_optn_i || !stall_i) state_nxt = S_REQ;
          else                           state_nxt = S_HOLD;
        end else if (pc_src_optn_i) begin
          // request still in flight for the old path: its response must be eaten
          state_nxt = S_DROP;
        end
      end
      S_HOLD: if (pc_src_optn_i || !stall_i) state_nxt = S_REQ;
      S_DROP: if (imem_rsp_valid_i) state_nxt = S_REQ;
      default: state_nxt = S_REQ;
    endcase
  end

  // outputs and datapath controls
  always_comb begin
    imem_req_valid_o = (state == S_REQ);
    load       = !pc_src_optn_i && !stall_i &&
                 ((state == S_WAIT && imem_rsp_valid_i) || state == S_HOLD);
    capture    = (state == S_WAIT) && imem_rsp_valid_i && !pc_src_optn_i && stall_i;
    load_instr = (state == S_HOLD) ? hold_q : imem_rsp_data_i;
    // a redirect always wins over a sequential advance, in every state
    if (pc_src_optn_i) pc_nxt = target_addr_i;
    else if (load)     pc_nxt = pc_plus4;
    else               pc_nxt = pc_q;
  end

  assign imem_addr_o = pc_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pc_q   <= RESET_PC;
      hold_q <= NOP_INSTR;
    end else begin
      pc_q <= pc_nxt;
      if (capture) hold_q <= imem_rsp_data_i;
    end
  end

  // IF/ID register: reset > flush > stall > load/bubble
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      if_id_valid_o    <= 1'b0;
      if_id_pc_o       <= 32'h0;
      if_id_pc_plus4_o <= 32'h0;
      if_id_instr_o    <= NOP_INSTR;
    end else if (flush_req_i) begin
      if_id_valid_o <= 1'b0;
      if_id_instr_o <= NOP_INSTR;
    end else if (!stall_i) begin
      if_id_valid_o <= load;
      if (load) begin
        if_id_pc_o       <= pc_q;
        if_id_pc_plus4_o <= pc_plus4;
        if_id_instr_o    <= load_instr;
      end
    end
  end

`ifdef FETCH_PERF_CNT_EN
  logic kill;
  assign kill = (state == S_WAIT && imem_rsp_valid_i && pc_src_optn_i) ||
                (state == S_HOLD && pc_src_optn_i) ||
                (state == S_DROP && imem_rsp_valid_i);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      perf_fetch_cnt_o <= 32'h0;
      perf_kill_cnt_o  <= 32'h0;
    end else begin
      // a flush overrides the load, so that word never reaches IF/ID
      if (load && !flush_req_i) perf_fetch_cnt_o <= perf_fetch_cnt_o + 32'd1;
      if (kill)                 perf_kill_cnt_o  <= perf_kill_cnt_o + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Randomized bench for fetch_stage. A transaction-level model (in-flight flag,
// stale flag, one-entry hold slot) predicts the fetch port and IF/ID every
// cycle; a memory model answers accepted requests after 1..3 cycles.
// A second instance with RESET_PC = 0xFFFF_FFFC checks PC wrap.
module tb_fetch_stage;
  localparam logic [31:0] NOP  = 32'h0000_0013;
  localparam logic [31:0] RPC2 = 32'hFFFF_FFFC;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, stall, redir, flush, ready, rsp_v;
  logic [31:0] target, rsp_d;
  logic        req_v, v;
  logic [31:0] addr, pc, pc4, instr;

  logic        ready2, rsp_v2;
  logic [31:0] rsp_d2;
  logic        req_v2, v2;
  logic [31:0] addr2, pc2, pc42, instr2;

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] fcnt, kcnt, fcnt2, kcnt2;
`endif

  fetch_stage dut (
    .clk_i(clk), .rst_i(rst), .stall_i(stall), .pc_src_optn_i(redir),
    .flush_req_i(flush), .target_addr_i(target),
    .imem_req_valid_o(req_v), .imem_req_ready_i(ready), .imem_addr_o(addr),
    .imem_rsp_valid_i(rsp_v), .imem_rsp_data_i(rsp_d),
    .if_id_valid_o(v), .if_id_pc_o(pc), .if_id_pc_plus4_o(pc4), .if_id_instr_o(instr)
`ifdef FETCH_PERF_CNT_EN
    , .perf_fetch_cnt_o(fcnt), .perf_kill_cnt_o(kcnt)
`endif
  );

  fetch_stage #(.RESET_PC(RPC2)) dut2 (
    .clk_i(clk), .rst_i(rst), .stall_i(stall), .pc_src_optn_i(redir),
    .flush_req_i(flush), .target_addr_i(target),
    .imem_req_valid_o(req_v2), .imem_req_ready_i(ready2), .imem_addr_o(addr2),
    .imem_rsp_valid_i(rsp_v2), .imem_rsp_data_i(rsp_d2),
    .if_id_valid_o(v2), .if_id_pc_o(pc2), .if_id_pc_plus4_o(pc42), .if_id_instr_o(instr2)
`ifdef FETCH_PERF_CNT_EN
    , .perf_fetch_cnt_o(fcnt2), .perf_kill_cnt_o(kcnt2)
`endif
  );

  int n_chk = 0, n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    else n_pass++;
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B9) ^ 32'h0BAD_F00D;
  endfunction

  // reference model
  logic        m_out, m_stale, m_held;
  logic [31:0] m_hold, m_pc;
  logic        e_v;
  logic [31:0] e_pc, e_pc4, e_instr, e_fetch, e_kill;

  task automatic model_reset();
    m_out = 0; m_stale = 0; m_held = 0; m_hold = NOP; m_pc = 32'h0;
    e_v = 0; e_pc = 0; e_pc4 = 0; e_instr = NOP; e_fetch = 0; e_kill = 0;
  endtask

  // one clock edge worth of behaviour, from the inputs present at the edge
  task automatic model_step();
    logic        ld;
    logic [31:0] ld_w, pc_old;
    if (rst) begin model_reset(); return; end
    ld = 0; ld_w = 32'h0; pc_old = m_pc;
    if (m_out) begin
      if (rsp_v) begin
        m_out = 0;
        if (m_stale || redir) begin e_kill = e_kill + 1; m_stale = 0; end
        else if (!stall) begin ld = 1; ld_w = rsp_d; end
        else begin m_held = 1; m_hold = rsp_d; end
      end else if (redir) m_stale = 1;
    end else if (m_held) begin
      if (redir) begin m_held = 0; e_kill = e_kill + 1; end
      else if (!stall) begin m_held = 0; ld = 1; ld_w = m_hold; end
    end else if (ready) begin
      m_out = 1; m_stale = redir;
    end
    if (redir) m_pc = target;
    else if (ld) m_pc = pc_old + 32'd4;
    if (flush) begin
      e_v = 0; e_instr = NOP;
    end else if (!stall) begin
      e_v = ld;
      if (ld) begin
        e_pc = pc_old; e_pc4 = pc_old + 32'd4; e_instr = ld_w; e_fetch = e_fetch + 1;
      end
    end
  endtask

  task automatic check_all();
    chk("req_valid", {31'h0, req_v}, {31'h0, !m_out && !m_held});
    chk("imem_addr", addr, m_pc);
    chk("if_id_valid", {31'h0, v}, {31'h0, e_v});
    chk("if_id_instr", instr, e_instr);
    chk("if_id_pc", pc, e_pc);
    chk("if_id_pc4", pc4, e_pc4);
`ifdef FETCH_PERF_CNT_EN
    chk("perf_fetch", fcnt, e_fetch);
    chk("perf_kill", kcnt, e_kill);
`endif
  endtask

  // memory model
  logic        mem_busy;
  int          mem_cnt;
  logic [31:0] mem_addr;

  initial begin
    logic quiet, req_pred;
    rst = 1; stall = 0; redir = 0; flush = 0; target = 0; ready = 0;
    rsp_v = 0; rsp_d = 0; ready2 = 0; rsp_v2 = 0; rsp_d2 = 0;
    mem_busy = 0; mem_cnt = 0; mem_addr = 0;
    model_reset();

    for (int cyc = 0; cyc < 4000; cyc++) begin
      @(negedge clk);
      quiet = (cyc < 40);
      rst   = (cyc < 2) || ($urandom_range(0, 299) == 0);
      if (quiet) begin
        stall = 0; redir = 0; flush = 0; ready = 1;
      end else begin
        stall  = ($urandom_range(0, 3) == 0);
        redir  = ($urandom_range(0, 9) == 0);
        flush  = redir ? ($urandom_range(0, 1) == 0) : ($urandom_range(0, 14) == 0);
        ready  = ($urandom_range(0, 3) != 0);
        target = ($urandom_range(0, 7) == 0) ? RPC2 : ($urandom & 32'h0000_0FFC);
      end
      if (rst) mem_busy = 0;
      rsp_v = mem_busy && (mem_cnt == 0);
      rsp_d = rsp_v ? mem_word(mem_addr) : $urandom;

      @(posedge clk);
      req_pred = !m_out && !m_held;
      if (!rst) begin
        if (rsp_v) mem_busy = 0;
        else if (mem_busy) mem_cnt--;
        if (req_pred && ready) begin
          mem_busy = 1;
          mem_cnt  = quiet ? 0 : $urandom_range(0, 2);
          mem_addr = m_pc;
        end
      end
      model_step();
      #1;
      check_all();
    end

    // RESET_PC wrap on the second instance
    @(negedge clk);
    rst = 1; stall = 0; redir = 0; flush = 0; ready = 0; rsp_v = 0; ready2 = 0; rsp_v2 = 0;
    @(negedge clk);
    rst = 0;
    chk("w_rst_addr", addr2, RPC2);
    chk("w_rst_req", {31'h0, req_v2}, 32'h1);
    chk("w_rst_valid", {31'h0, v2}, 32'h0);
    chk("w_rst_instr", instr2, NOP);
    ready2 = 1;
    @(negedge clk);
    ready2 = 0; rsp_v2 = 1; rsp_d2 = 32'h1234_5678;
    chk("w_wait_req", {31'h0, req_v2}, 32'h0);
    @(negedge clk);
    rsp_v2 = 0;
    chk("w_valid", {31'h0, v2}, 32'h1);
    chk("w_pc", pc2, RPC2);
    chk("w_pc4", pc42, 32'h0);
    chk("w_instr", instr2, 32'h1234_5678);
    chk("w_next_addr", addr2, 32'h0);
    chk("w_next_req", {31'h0, req_v2}, 32'h1);
`ifdef FETCH_PERF_CNT_EN
    chk("w_fetch_cnt", fcnt2, 32'h1);
    chk("w_kill_cnt", kcnt2, 32'h0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction-fetch stage that owns the program counter and drives the instruction-memory handshake. It also owns the IF/ID pipeline register. It sits directly upstream of decode and consumes the redirect/flush outputs of `flow_controller`: `pc_src_optn_o`, `flush_req_o` and `final_target_addr_o`. It keeps at most one memory request in flight, discards stale responses after a redirect, and buffers one fetched instruction while decode is stalled.

## Interface
- `RESET_PC`, 32'h0000_0000: PC value loaded on reset.
- `NOP_INSTR`, 32'h0000_0013: encoding placed in IF/ID on reset and flush (`addi x0,x0,0`).

- `clk_i`  in  1  single clock; all state changes on the rising edge.
- `rst_i`  in  1  reset, synchronous, active-high.
- `stall_i`  in  1  hazard-unit hold: IF/ID must not advance.
- `pc_src_optn_i`  in  1  redirect PC to `target_addr_i`.
- `flush_req_i`  in  1  kill the IF/ID contents.
- `target_addr_i`  in  32  redirect target.
- `imem_req_valid_o`  out  1  fetch request valid.
- `imem_req_ready_i`  in  1  memory accepts the request.
- `imem_addr_o`  out  32  fetch address (= `pc_q`).
- `imem_rsp_valid_i`  in  1  response data valid.
- `imem_rsp_data_i`  in  32  fetched instruction.
- `if_id_valid_o`  out  1  IF/ID holds a live instruction.
- `if_id_pc_o`  out  32  PC of the IF/ID instruction.
- `if_id_pc_plus4_o`  out  32  that PC + 4.
- `if_id_instr_o`  out  32  instruction word.

## Operation
- The FSM has four states: REQ, WAIT, HOLD and DROP.
- `imem_req_valid_o` = (state==REQ). `imem_addr_o` = `pc_q`. Both are combinational from registers.
- **REQ**
  - Handshake fires (valid & ready) → WAIT.
  - Redirect in the same cycle as the handshake → DROP, with `pc_q` ← target.
  - Redirect without a handshake → stay in REQ, with `pc_q` ← target.
- **WAIT**, on `imem_rsp_valid_i`:
  - Redirect this cycle → response discarded, `pc_q` ← target, go to REQ.
  - No redirect and `stall_i`=0 → IF/ID ← {1, `pc_q`, `pc_q`+4, data}; `pc_q` ← `pc_q`+4; go to REQ.
  - No redirect and `stall_i`=1 → data captured in the hold buffer; go to HOLD.
  - Redirect without a response → DROP, with `pc_q` ← target.
- **HOLD**
  - `stall_i` falls → IF/ID loads from the buffer, `pc_q` ← `pc_q`+4, go to REQ.
  - Redirect → buffer discarded, `pc_q` ← target, go to REQ.
- **DROP**
  - Wait for `imem_rsp_valid_i`, discard the data, go to REQ.
  - A redirect while in DROP only updates `pc_q`.
- **IF/ID register**
  - Priority: `rst_i` > `flush_req_i` > `stall_i` > load.
  - Flush: valid ← 0, instr ← `NOP_INSTR`. This applies even when `stall_i`=1.
  - Stall: hold all fields.
  - Not stalled and nothing to load: valid ← 0 (bubble); other fields hold.
- **Independent controls**: `pc_src_optn_i` alone redirects without clearing IF/ID. `flush_req_i` alone clears IF/ID without touching `pc_q`.
- **Arithmetic**: `pc_q`+4 is 32-bit modulo, so 0xFFFF_FFFC wraps to 0x0000_0000. Target bits are used unmodified.

## Timing
- **Reset values** (after a reset edge):
  - State REQ, `pc_q`=`RESET_PC`.
  - `imem_req_valid_o`=1, `imem_addr_o`=`RESET_PC`.
  - `if_id_valid_o`=0, `if_id_instr_o`=`NOP_INSTR`, `if_id_pc_o`=0, `if_id_pc_plus4_o`=0.
- Reset mid-operation drops any outstanding or held fetch. A response arriving after reset is ignored only while the state is DROP; memory must not return responses for requests made before reset.
- **Latency**
  - Request accepted at edge N.
  - Response visible in cycle N+k (k≥1).
  - IF/ID valid after edge N+k.
  - Next request is presented in cycle N+k+1.
  - Best-case throughput is one instruction per 2 cycles.
- **Redirect**: redirect sampled at edge N → `imem_addr_o`=target in cycle N+1.
- A response and a redirect in the same cycle always discard the response.
- At most one outstanding request; no request is issued in WAIT, HOLD or DROP.

## Configuration
- `FETCH_PERF_CNT_EN` defined:
  - Adds outputs `perf_fetch_cnt_o[31:0]`, incremented on each IF/ID load with valid=1.
  - Adds `perf_kill_cnt_o[31:0]`, incremented on each discarded response or discarded hold buffer.
  - Both counters are zero on reset and wrap modulo 2^32.
- Undefined: these ports and counters do not exist; all other behaviour is identical.

## Test plan
- Reset, then ready=1 and response one cycle after each accept → IF/ID PCs 0x0, 0x4, 0x8 with matching instructions; a new valid every 2 cycles.
- Redirect to 0x0000_0400 with flush while WAIT, response arriving one cycle later → response dropped, IF/ID valid=0 with NOP, next `imem_addr_o`=0x400.
- Response arrives with `stall_i`=1 for 3 cycles → IF/ID holds the old contents, no new request issued; the buffered instruction appears one edge after the stall drops.
- `flush_req_i`=1 while `stall_i`=1 → `if_id_valid_o`=0, `if_id_instr_o`=0x0000_0013.
- Redirect in the same cycle as a REQ handshake → state DROP; the returned word is not loaded; the next request is to the target.
- `RESET_PC`=0xFFFF_FFFC → first IF/ID `pc_plus4`=0x0, next fetch address 0x0; with `FETCH_PERF_CNT_EN`, fetch count=1 and kill count=0.
